irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Collects NUM_SRC external interrupt lines and selects one at a time by fixed priority (lowest index wins).
- Presents the winner to the core exception unit as a level request plus an 8-bit id (int_req/int_id).
- Holds the id stable until the exception unit accepts it, then blocks new requests until the handler's mret completes.
- Sits between the peripheral interrupt wires and the exception unit in the core top level.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32)
EDGE_MASK, {NUM_SRC{1'b1}}, per-source: 1 = rising-edge triggered, 0 = level triggered
ID_BASE, 8'h0, id reported for source 0; source k reports ID_BASE+k (8-bit, wraps mod 256)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
irq_src_i  input  NUM_SRC  raw asynchronous interrupt lines
irq_en_i  input  NUM_SRC  per-source enable (from CSR/MMIO), synchronous to clk
irq_ack_i  input  1  single-cycle pulse: exception unit has taken the presented interrupt (wrote mcause)
irq_done_i  input  1  single-cycle pulse: handler returned (mret executed)
int_req_o  output  1  interrupt request to exception unit
int_id_o  output  8  id of requested interrupt
pending_o  output  NUM_SRC  current pending vector (debug/MMIO readback)
busy_o  output  1  high in S_REQ or S_ACTIVE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n); all flops are cleared on rst_n low.
- Reset values: int_req_o=0, int_id_o=0, pending_o=0, busy_o=0, state=S_IDLE, all synchronizer and edge flops=0.
- Input conditioning: each irq_src_i bit passes through a 2-flop synchronizer (s1, s2), plus a third flop s3 for edge detect.
- Pending update, per source k, at every clock edge:
  - Edge source: pend[k] <= (pend[k] & ~clr[k]) | (s2[k] & ~s3[k]).
  - Level source: pend[k] <= s2[k].
  - clr[k] = irq_ack_i in S_REQ with latched index == k.
  - Set wins over clear in the same cycle (new edge coincident with ack stays pending).
  - Level sources are never cleared by ack; the handler must deassert the line.
- Eligible vector = pend & irq_en_i. Winner = lowest set index (combinational priority encode).
- Latency: a source held high across clock edges e1..e4 gives pend set after e3 and int_req_o=1 after e4 (4 cycles, idle arbiter, enabled source).
- A source high at reset release is treated as a rising edge (s3 resets to 0).
- FSM, one-hot, states S_IDLE, S_REQ, S_ACTIVE:
  - S_IDLE: if eligible != 0, latch winner index and id (ID_BASE+idx), go to S_REQ. int_req_o=0. irq_ack_i and irq_done_i are ignored.
  - S_REQ: int_req_o=1, int_id_o held at the latched value. A higher-priority arrival does not change the id (no pre-emption of a presented request).
    - On irq_ack_i: go to S_ACTIVE.
    - Else if the latched source's irq_en_i drops, or its pend clears (level line dropped): go to S_IDLE, int_req_o low next cycle (withdraw).
  - S_ACTIVE: int_req_o=0, int_id_o holds the last id. On irq_done_i go to S_IDLE; the next arbitration may present a request on the following cycle.
  - Illegal or non-one-hot state goes to S_IDLE.
- irq_ack_i and irq_done_i in the same cycle while in S_REQ: treat as ack only (go to S_ACTIVE).
- int_req_o and int_id_o are registered outputs, and the output registers are the only source of int_req_o/int_id_o. No combinational path from any input to int_req_o or int_id_o.
- Enables are not synchronized; a disabled source keeps accumulating pending (edge) and is presented as soon as it is enabled.

Test Plan:
- Reset, then pulse irq_src_i[2] (edge) high for 3 cycles with en=8'hFF -> int_req_o=1 on the 4th edge after the rise, int_id_o=8'h02; ack pulse -> int_req_o=0, pend[2]=0, busy_o=1; done pulse -> busy_o=0.
- Sources 5 and 1 rise in the same cycle -> id 8'h01 presented first; after ack+done, id 8'h05 presented 1 cycle after done.
- In S_REQ with id 3, source 0 rises -> int_id_o stays 8'h03 until ack; source 0 is presented after done.
- Level source 4 (EDGE_MASK bit4=0) held high, ack+done without dropping the line -> re-presented with id 8'h04; drop the line while in S_REQ -> int_req_o falls within 3 cycles, FSM back to S_IDLE.
- New edge on source 6 in the same cycle as its ack -> pend[6] remains 1 and is re-presented after done. Separately, clear irq_en_i[6] while in S_REQ -> request withdrawn, pend[6] retained.
- Assert rst_n=0 asynchronously mid S_ACTIVE -> all outputs 0 immediately. Release with irq_src_i[0] already high (edge) -> request with id ID_BASE+0 after 4 cycles.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: fixed-priority interrupt arbiter (lowest index wins) with synchronized
// edge/level sources and a request -> ack -> mret handshake toward the exception unit.
module irq_arbiter #(
    parameter int                 NUM_SRC   = 8,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
    parameter logic [7:0]         ID_BASE   = 8'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] irq_en_i,
    input  logic               irq_ack_i,
    input  logic               irq_done_i,
    output logic               int_req_o,
    output logic [7:0]         int_id_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic               busy_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_REQ    = 3'b010,
        S_ACTIVE = 3'b100
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_SRC-1:0] r_s1, r_s2, r_s3, r_pend;
    logic [NUM_SRC-1:0] w_pend_nxt, w_sel, w_clr, w_elig;
    logic [4:0]         r_idx, w_idx_nxt, w_win;
    logic [7:0]         r_id, w_id_nxt;
    logic               r_req;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sel
        assign w_sel[i] = (r_idx == 5'(i));
    end

    assign w_elig     = r_pend & irq_en_i;
    assign w_clr      = w_sel & {NUM_SRC{irq_ack_i && r_state == S_REQ}};
    // a fresh edge in the ack cycle survives the clear; level sources just track the line
    assign w_pend_nxt = (EDGE_MASK & ((r_pend & ~w_clr) | (r_s2 & ~r_s3))) | (~EDGE_MASK & r_s2);

    always_comb begin
        w_win = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (w_elig[k]) w_win = 5'(k);
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = r_idx;
        w_id_nxt    = r_id;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = S_REQ;
                    w_idx_nxt   = w_win;
                    w_id_nxt    = ID_BASE + {3'b000, w_win};
                end
            end
            // withdraw when the presented source is disabled or its pending is about to drop
            S_REQ:    w_state_nxt = irq_ack_i ? S_ACTIVE :
                                    (|(w_sel & w_pend_nxt & irq_en_i)) ? S_REQ : S_IDLE;
            S_ACTIVE: w_state_nxt = irq_done_i ? S_IDLE : S_ACTIVE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_pend  <= '0;
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_id    <= '0;
            r_req   <= 1'b0;
        end else begin
            r_s1    <= irq_src_i;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pend  <= w_pend_nxt;
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_id    <= w_id_nxt;
            r_req   <= (w_state_nxt == S_REQ);
        end
    end

    assign int_req_o = r_req;
    assign int_id_o  = r_id;
    assign pending_o = r_pend;
    assign busy_o    = (r_state == S_REQ) || (r_state == S_ACTIVE);
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus randomized traffic against a behavioural
// model of the arbiter built from line history, pending bits and a three-mode handshake.
module tb_irq_arbiter;
    localparam logic [7:0] EDGE = 8'hEF;
    localparam logic [7:0] BASE = 8'h00;
    localparam int M_IDLE = 0, M_REQ = 1, M_ACT = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] irq_src = 8'h00, irq_en = 8'hFF;
    logic       irq_ack = 1'b0, irq_done = 1'b0;
    logic       int_req, busy;
    logic [7:0] int_id, pending;
    int         n_tests = 0, n_fail = 0;

    irq_arbiter #(.NUM_SRC(8), .EDGE_MASK(EDGE), .ID_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src_i(irq_src), .irq_en_i(irq_en),
        .irq_ack_i(irq_ack), .irq_done_i(irq_done), .int_req_o(int_req),
        .int_id_o(int_id), .pending_o(pending), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // h1/h2/h3: line values seen at the last three clock edges (most recent first)
    logic [7:0] h1, h2, h3, m_pend, m_id, m_np, m_clr;
    int         m_mode, m_idx;

    function automatic int lowest(input logic [7:0] v);
        for (int k = 0; k < 8; k++)
            if (v[k]) return k;
        return 0;
    endfunction

    always_comb begin
        m_clr = (m_mode == M_REQ && irq_ack) ? (8'd1 << m_idx) : 8'd0;
        m_np  = (EDGE & ((m_pend & ~m_clr) | (h2 & ~h3))) | (~EDGE & h2);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= 0; h2 <= 0; h3 <= 0; m_pend <= 0; m_id <= 0; m_mode <= M_IDLE; m_idx <= 0;
        end else begin
            h1 <= irq_src; h2 <= h1; h3 <= h2; m_pend <= m_np;
            case (m_mode)
                M_IDLE: if ((m_pend & irq_en) != 0) begin
                    m_mode <= M_REQ;
                    m_idx  <= lowest(m_pend & irq_en);
                    m_id   <= BASE + 8'(lowest(m_pend & irq_en));
                end
                M_REQ: if (irq_ack) m_mode <= M_ACT;
                       else if ((m_np & irq_en & (8'd1 << m_idx)) == 0) m_mode <= M_IDLE;
                default: if (irq_done) m_mode <= M_IDLE;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack;
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    endtask

    task automatic pulse_done;
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        for (int c = 0; c < budget && !int_req; c++) tick(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; irq_src = 8'h00; irq_en = 8'hFF; tick(3);
        n_tests++;
        if ({int_req, int_id, pending, busy} !== 18'h0) begin
            n_fail++; $display("FAIL reset_outputs: got req=%b id=%h pend=%h busy=%b, want all 0", int_req, int_id, pending, busy);
        end
        rst_n = 1'b1; tick(2);
        n_tests++;
        if (int_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got req=%b busy=%b, want 0 0", int_req, busy);
        end
    endtask

    task automatic test_basic;
        irq_src[2] = 1'b1; tick(2);
        n_tests++;
        if (pending[2] !== 1'b0 || int_req !== 1'b0) begin
            n_fail++; $display("FAIL basic_e2: got pend2=%b req=%b, want 0 0", pending[2], int_req);
        end
        tick(1);
        n_tests++;
        if (pending[2] !== 1'b1 || int_req !== 1'b0) begin
            n_fail++; $display("FAIL basic_e3: got pend2=%b req=%b, want 1 0", pending[2], int_req);
        end
        irq_src[2] = 1'b0; tick(1);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h02 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_e4: got req=%b id=%h busy=%b, want 1 02 1", int_req, int_id, busy);
        end
        pulse_ack;
        n_tests++;
        if (int_req !== 1'b0 || pending[2] !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_ack: got req=%b pend2=%b busy=%b, want 0 0 1", int_req, pending[2], busy);
        end
        pulse_done;
        n_tests++;
        if (busy !== 1'b0 || int_req !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: got busy=%b req=%b, want 0 0", busy, int_req);
        end
    endtask

    task automatic test_priority;
        irq_src[5] = 1'b1; irq_src[1] = 1'b1; tick(4);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h01) begin
            n_fail++; $display("FAIL prio_first: got req=%b id=%h, want 1 01", int_req, int_id);
        end
        pulse_ack; pulse_done;
        n_tests++;
        if (int_req !== 1'b0 || pending[5] !== 1'b1) begin
            n_fail++; $display("FAIL prio_gap: got req=%b pend5=%b, want 0 1", int_req, pending[5]);
        end
        tick(1);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h05) begin
            n_fail++; $display("FAIL prio_second: got req=%b id=%h, want 1 05", int_req, int_id);
        end
        pulse_ack; pulse_done; irq_src = 8'h00;
    endtask

    task automatic test_no_preempt;
        irq_src[3] = 1'b1; wait_req(10);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h03) begin
            n_fail++; $display("FAIL nopre_first: got req=%b id=%h, want 1 03", int_req, int_id);
        end
        irq_src[0] = 1'b1; tick(6);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h03 || pending[0] !== 1'b1) begin
            n_fail++; $display("FAIL nopre_hold: got req=%b id=%h pend0=%b, want 1 03 1", int_req, int_id, pending[0]);
        end
        pulse_ack;
        n_tests++;
        if (int_req !== 1'b0 || int_id !== 8'h03) begin
            n_fail++; $display("FAIL nopre_active: got req=%b id=%h, want 0 03", int_req, int_id);
        end
        pulse_done; wait_req(4);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h00) begin
            n_fail++; $display("FAIL nopre_after: got req=%b id=%h, want 1 00", int_req, int_id);
        end
        pulse_ack; pulse_done; irq_src = 8'h00;
    endtask

    task automatic test_level;
        irq_src[4] = 1'b1; wait_req(10);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h04) begin
            n_fail++; $display("FAIL level_first: got req=%b id=%h, want 1 04", int_req, int_id);
        end
        pulse_ack;
        n_tests++;
        if (pending[4] !== 1'b1) begin
            n_fail++; $display("FAIL level_ack_keep: got pend4=%b, want 1", pending[4]);
        end
        pulse_done; wait_req(4);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h04) begin
            n_fail++; $display("FAIL level_represent: got req=%b id=%h, want 1 04", int_req, int_id);
        end
        irq_src[4] = 1'b0;
        for (int c = 0; c < 3 && int_req; c++) tick(1);
        n_tests++;
        if (int_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL level_withdraw: got req=%b busy=%b, want 0 0", int_req, busy);
        end
    endtask

    task automatic test_edge_ack;
        irq_src[6] = 1'b1; tick(2); irq_src[6] = 1'b0; wait_req(10);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h06) begin
            n_fail++; $display("FAIL edgeack_first: got req=%b id=%h, want 1 06", int_req, int_id);
        end
        tick(2);
        irq_src[6] = 1'b1; tick(2);
        pulse_ack;
        n_tests++;
        if (pending[6] !== 1'b1 || busy !== 1'b1 || int_req !== 1'b0) begin
            n_fail++; $display("FAIL edgeack_keep: got pend6=%b busy=%b req=%b, want 1 1 0", pending[6], busy, int_req);
        end
        pulse_done; wait_req(4);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h06) begin
            n_fail++; $display("FAIL edgeack_represent: got req=%b id=%h, want 1 06", int_req, int_id);
        end
        irq_en[6] = 1'b0; tick(1);
        n_tests++;
        if (int_req !== 1'b0 || busy !== 1'b0 || pending[6] !== 1'b1) begin
            n_fail++; $display("FAIL en_withdraw: got req=%b busy=%b pend6=%b, want 0 0 1", int_req, busy, pending[6]);
        end
        irq_en[6] = 1'b1; wait_req(4);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== 8'h06) begin
            n_fail++; $display("FAIL en_restore: got req=%b id=%h, want 1 06", int_req, int_id);
        end
        pulse_ack; pulse_done; irq_src = 8'h00;
    endtask

    task automatic test_async_reset;
        irq_src[1] = 1'b1; wait_req(10); pulse_ack; irq_src[1] = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || int_id !== 8'h01) begin
            n_fail++; $display("FAIL arst_active: got busy=%b id=%h, want 1 01", busy, int_id);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({int_req, int_id, pending, busy} !== 18'h0) begin
            n_fail++; $display("FAIL arst_immediate: got req=%b id=%h pend=%h busy=%b, want all 0", int_req, int_id, pending, busy);
        end
        irq_src[0] = 1'b1; tick(2); rst_n = 1'b1; tick(3);
        n_tests++;
        if (int_req !== 1'b0 || pending[0] !== 1'b1) begin
            n_fail++; $display("FAIL arst_rel_e3: got req=%b pend0=%b, want 0 1", int_req, pending[0]);
        end
        tick(1);
        n_tests++;
        if (int_req !== 1'b1 || int_id !== BASE) begin
            n_fail++; $display("FAIL arst_rel_e4: got req=%b id=%h, want 1 %h", int_req, int_id, BASE);
        end
        pulse_ack; pulse_done; irq_src = 8'h00;
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            irq_src  = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) irq_en = 8'($urandom) | 8'($urandom);
            irq_ack  = ($urandom_range(0, 3) == 0);
            irq_done = ($urandom_range(0, 4) == 0);
            tick(1);
            n_tests++;
            if (int_req !== (m_mode == M_REQ)) begin
                n_fail++; $display("FAIL rand_req cyc %0d: got %b, want %b", i, int_req, m_mode == M_REQ);
            end
            n_tests++;
            if (int_id !== m_id) begin
                n_fail++; $display("FAIL rand_id cyc %0d: got %h, want %h", i, int_id, m_id);
            end
            n_tests++;
            if (pending !== m_pend) begin
                n_fail++; $display("FAIL rand_pend cyc %0d: got %h, want %h", i, pending, m_pend);
            end
            n_tests++;
            if (busy !== (m_mode != M_IDLE)) begin
                n_fail++; $display("FAIL rand_busy cyc %0d: got %b, want %b", i, busy, m_mode != M_IDLE);
            end
        end
        irq_ack = 1'b0; irq_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_priority;
        test_no_preempt;
        test_level;
        test_edge_ack;
        test_async_reset;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
